// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: data width, access-size
// encodings, FSM state type, the captured request payload and the alignment rule.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANE_W = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } state_t;

  // Request fields needed after the accept cycle (word address is kept in readAddress).
  typedef struct packed {
    logic [1:0]        size;
    logic              sgn;
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Size 11 is always a fault; halves need an even lane, words need lane 0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [LANE_W-1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return (lane != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for a 32-bit little-endian word.
//   lane, size, sgn : access lane (byte offset), size code and sign-extend flag
//   rdata           : word read from memory
//   wdata           : right-justified store data
//   load_c          : addressed lane(s) of rdata, sign/zero-extended (word passes through)
//   merge_c         : rdata with the addressed lane(s) replaced by wdata (word: wdata)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [LANE_W-1:0] lane,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_c,
  output logic [DATA_W-1:0] merge_c
);

  logic [DATA_W-1:0] shifted;

  // Halves only ever use lanes 0 and 2, so lane[1] alone selects the half.
  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    load_c  = rdata;
    merge_c = rdata;
    case (size)
      SZ_BYTE: begin
        load_c = {{(DATA_W - 8){sgn & shifted[7]}}, shifted[7:0]};
        merge_c[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_c = {{(DATA_W - 16){sgn & shifted[15]}}, shifted[15:0]};
        merge_c[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_c  = rdata;
        merge_c = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit in front of a word-wide data memory.
// Accepts byte-addressed loads/stores, performs sub-word stores as read-modify-write,
// flags misaligned accesses without touching memory, and returns extended load data.
//   clk, rst_n                     : clock, async active-low reset
//   reqValid/reqReady              : request handshake (ready only while idle)
//   reqWrite/reqSize/reqSigned     : store flag, size code, sign-extend flag
//   reqAddr/reqWData               : byte address, right-justified store data
//   rspValid/rspData/rspMisalign   : one-cycle response strobe, load result, fault flag
//   readAddress/MemRead/readData   : memory read port (readData combinational)
//   writeAddress/writeData/MemWrite: memory write port
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned WADDR_W = 9,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [1:0]           reqSize,
  input  logic                 reqSigned,
  input  logic [WADDR_W+1:0]   reqAddr,
  input  logic [DATA_W-1:0]    reqWData,
  output logic                 rspValid,
  output logic [DATA_W-1:0]    rspData,
  output logic                 rspMisalign,
  output logic [WADDR_W-1:0]   readAddress,
  output logic [WADDR_W-1:0]   writeAddress,
  output logic [DATA_W-1:0]    writeData,
  output logic                 MemRead,
  output logic                 MemWrite,
  input  logic [DATA_W-1:0]    readData
);

  state_t state_q, state_d;
  req_t   req_q, req_d;

  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_mis_q, rsp_mis_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [WADDR_W-1:0] raddr_q, raddr_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [WADDR_W-1:0] req_word;
  logic [LANE_W-1:0]  req_lane;
  logic [DATA_W-1:0]  load_c;
  logic [DATA_W-1:0]  merge_c;

  assign req_word = reqAddr[WADDR_W+1:2];
  assign req_lane = reqAddr[1:0];

  // Lane logic always works on the live memory word and the captured request.
  lsu_lane_align u_align (
    .lane    (req_q.lane),
    .size    (req_q.size),
    .sgn     (req_q.sgn),
    .rdata   (readData),
    .wdata   (req_q.wdata),
    .load_c  (load_c),
    .merge_c (merge_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_mis_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mis_q   <= rsp_mis_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Next state and next output values; outputs for a state are set on entry.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_mis_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (reqValid) begin
          ready_d = 1'b0;
          req_d   = '{size: reqSize, sgn: reqSigned, lane: req_lane, wdata: reqWData};
          if (is_misaligned(reqSize, req_lane)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_mis_d   = 1'b1;
          end else if (!reqWrite) begin
            state_d    = ST_LOAD;
            mem_read_d = 1'b1;
            raddr_d    = req_word;
          end else if (reqSize == SZ_WORD) begin
            state_d     = ST_WRITE;
            mem_write_d = 1'b1;
            waddr_d     = req_word;
            wdata_d     = reqWData;
          end else begin
            state_d    = ST_RMW_RD;
            mem_read_d = 1'b1;
            raddr_d    = req_word;
          end
        end
      end
      ST_LOAD: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = load_c;
      end
      ST_RMW_RD: begin
        // Write back to the word just read, with the new lane(s) merged in.
        state_d     = ST_WRITE;
        mem_write_d = 1'b1;
        waddr_d     = raddr_q;
        wdata_d     = merge_c;
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign reqReady     = ready_q;
  assign rspValid     = rsp_valid_q;
  assign rspData      = rsp_data_q;
  assign rspMisalign  = rsp_mis_q;
  assign MemRead      = mem_read_q;
  assign MemWrite     = mem_write_q;
  assign readAddress  = raddr_q;
  assign writeAddress = waddr_q;
  assign writeData    = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a 512-word memory fixture, a transaction-level reference
// model (schedule of response/enable cycles plus a reference memory), a per-cycle
// compare process, directed scenarios with literal expectations, then random traffic.
module tb_lsu_mem_stage;

  localparam int unsigned WADDR_W = 9;
  localparam int unsigned AW      = WADDR_W + 2;
  localparam int unsigned NWORDS  = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              reqValid;
  logic              reqReady;
  logic              reqWrite;
  logic [1:0]        reqSize;
  logic              reqSigned;
  logic [AW-1:0]     reqAddr;
  logic [31:0]       reqWData;
  logic              rspValid;
  logic [31:0]       rspData;
  logic              rspMisalign;
  logic [WADDR_W-1:0] readAddress;
  logic [WADDR_W-1:0] writeAddress;
  logic [31:0]       writeData;
  logic              MemRead;
  logic              MemWrite;
  logic [31:0]       readData;

  lsu_mem_stage #(.WADDR_W(WADDR_W), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqWrite     (reqWrite),
    .reqSize      (reqSize),
    .reqSigned    (reqSigned),
    .reqAddr      (reqAddr),
    .reqWData     (reqWData),
    .rspValid     (rspValid),
    .rspData      (rspData),
    .rspMisalign  (rspMisalign),
    .readAddress  (readAddress),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .readData     (readData)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A5_0000;
  endfunction

  // Memory fixture: combinational read, write at the clock edge ending a MemWrite cycle.
  logic [31:0] mem [0:NWORDS-1];
  assign readData = mem[readAddress];

  initial begin
    for (int i = 0; i < int'(NWORDS); i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (MemWrite) mem[writeAddress] <= writeData;
    end
  end

  // Reference model: cycle index cyc counts clock edges since start (frozen in reset).
  logic [31:0] ref_mem [0:NWORDS-1];
  int          cyc      = 0;
  int          m_free   = 0;
  int          m_rsp_at = -1;
  int          m_rd_at  = -1;
  int          m_wr_at  = -1;
  logic [31:0] m_data   = '0;
  logic        m_mis    = 1'b0;
  int          m_addr   = 0;
  logic [31:0] m_wr_data = '0;
  bit          pend     = 1'b0;

  task automatic model_accept(input int n);
    int          w, ln, sh, lat;
    logic [31:0] old, v, mask;
    bit          bad;
    w   = int'(reqAddr) / 4;
    ln  = int'(reqAddr) % 4;
    sh  = 8 * ln;
    bad = (reqSize == 2'd3) || (reqSize == 2'd1 && (ln % 2) != 0) || (reqSize == 2'd2 && ln != 0);
    old = ref_mem[w];
    m_rd_at = -1;
    m_wr_at = -1;
    m_mis   = 1'b0;
    m_data  = '0;
    m_addr  = w;
    if (bad) begin
      m_mis = 1'b1;
      lat   = 0;
    end else if (!reqWrite) begin
      lat     = 1;
      m_rd_at = n;
      v = old >> sh;
      if (reqSize == 2'd0) begin
        v = v & 32'hFF;
        if (reqSigned && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (reqSize == 2'd1) begin
        v = v & 32'hFFFF;
        if (reqSigned && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      m_data = v;
    end else if (reqSize == 2'd2) begin
      lat       = 1;
      m_wr_at   = n;
      m_wr_data = reqWData;
      pend      = 1'b1;
    end else begin
      lat       = 2;
      m_rd_at   = n;
      m_wr_at   = n + 1;
      mask      = (reqSize == 2'd0) ? 32'hFF : 32'hFFFF;
      m_wr_data = (old & ~(mask << sh)) | ((reqWData & mask) << sh);
      pend      = 1'b1;
    end
    m_rsp_at = n + lat;
    m_free   = n + lat + 1;
  endtask

  initial begin
    for (int i = 0; i < int'(NWORDS); i++) ref_mem[i] = init_word(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_free   = cyc;
        m_rsp_at = -1;
        m_rd_at  = -1;
        m_wr_at  = -1;
        pend     = 1'b0;
      end else begin
        if (pend && cyc == m_wr_at) begin
          ref_mem[m_addr] = m_wr_data;
          pend = 1'b0;
        end
        if (cyc >= m_free && reqValid) model_accept(cyc + 1);
        cyc++;
      end
    end
  end

  // Compare process: every cycle, shortly after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("reqReady", reqReady, 32'(cyc >= m_free));
      chk("rspValid", rspValid, 32'(cyc == m_rsp_at));
      chk("MemRead",  MemRead,  32'(cyc == m_rd_at));
      chk("MemWrite", MemWrite, 32'(cyc == m_wr_at));
      if (cyc == m_rsp_at) begin
        chk("rspData",     rspData,     m_data);
        chk("rspMisalign", rspMisalign, 32'(m_mis));
      end
      if (cyc == m_rd_at)
        chk("readAddress", 32'(readAddress), 32'(m_addr));
      if (cyc == m_wr_at) begin
        chk("writeAddress", 32'(writeAddress), 32'(m_addr));
        chk("writeData",    writeData,         m_wr_data);
      end
    end
  end

  // One request: wait for ready, drop valid after accept, wait for the response.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        output logic [31:0] data, output logic mis,
                        output int lat, output int nwr, output int nrd);
    int guard;
    @(negedge clk);
    reqValid  = 1'b1;
    reqWrite  = wr;
    reqSize   = sz;
    reqSigned = sg;
    reqAddr   = a;
    reqWData  = wd;
    guard = 0;
    while (!reqReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    reqValid = 1'b0;
    lat  = 1;
    nwr  = 0;
    nrd  = 0;
    data = '0;
    mis  = 1'b0;
    while (!rspValid && lat < 10) begin
      nwr += int'(MemWrite);
      nrd += int'(MemRead);
      @(negedge clk);
      lat++;
    end
    if (rspValid && guard < 20) begin
      data = rspData;
      mis  = rspMisalign;
    end else begin
      lat = -1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        mis;
    int          lat, nwr, nrd, cnt_wr, cnt_rsp, bad_words, r;

    rst_n     = 1'b1;
    reqValid  = 1'b0;
    reqWrite  = 1'b0;
    reqSize   = 2'd0;
    reqSigned = 1'b0;
    reqAddr   = '0;
    reqWData  = '0;
    #1 rst_n  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_reqReady",     reqReady,            32'd1);
    chk("rst_rspValid",     rspValid,            32'd0);
    chk("rst_rspData",      rspData,             32'd0);
    chk("rst_rspMisalign",  rspMisalign,         32'd0);
    chk("rst_MemRead",      MemRead,             32'd0);
    chk("rst_MemWrite",     MemWrite,            32'd0);
    chk("rst_readAddress",  32'(readAddress),    32'd0);
    chk("rst_writeAddress", 32'(writeAddress),   32'd0);
    chk("rst_writeData",    writeData,           32'd0);
    rst_n = 1'b1;

    // Word store then word load.
    do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'hDEADBEEF, d, mis, lat, nwr, nrd);
    chk("sw_lat",        32'(lat),          32'd2);
    chk("sw_nwr",        32'(nwr),          32'd1);
    chk("sw_nrd",        32'(nrd),          32'd0);
    chk("sw_waddr",      32'(writeAddress), 32'd4);
    chk("sw_wdata",      writeData,         32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, d, mis, lat, nwr, nrd);
    chk("lw_lat",        32'(lat), 32'd2);
    chk("lw_data",       d,        32'hDEADBEEF);
    chk("lw_nrd",        32'(nrd), 32'd1);

    // Byte store via read-modify-write, then byte loads.
    do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'h11223344, d, mis, lat, nwr, nrd);
    do_req(1'b1, 2'd0, 1'b0, 11'h011, 32'h5555_55AA, d, mis, lat, nwr, nrd);
    chk("sb_lat",        32'(lat), 32'd3);
    chk("sb_nrd",        32'(nrd), 32'd1);
    chk("sb_nwr",        32'(nwr), 32'd1);
    chk("sb_mem",        mem[4],   32'h1122AA44);
    do_req(1'b0, 2'd0, 1'b1, 11'h011, 32'h0, d, mis, lat, nwr, nrd);
    chk("lb_signed",     d, 32'hFFFFFFAA);
    do_req(1'b0, 2'd0, 1'b0, 11'h011, 32'h0, d, mis, lat, nwr, nrd);
    chk("lb_unsigned",   d, 32'h000000AA);

    // Half loads.
    do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'h80011234, d, mis, lat, nwr, nrd);
    do_req(1'b0, 2'd1, 1'b1, 11'h012, 32'h0, d, mis, lat, nwr, nrd);
    chk("lh_hi_signed",   d, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b0, 11'h012, 32'h0, d, mis, lat, nwr, nrd);
    chk("lh_hi_unsigned", d, 32'h00008001);
    do_req(1'b0, 2'd1, 1'b1, 11'h010, 32'h0, d, mis, lat, nwr, nrd);
    chk("lh_lo_signed",   d, 32'h00001234);

    // Misaligned accesses.
    do_req(1'b0, 2'd2, 1'b0, 11'h013, 32'h0, d, mis, lat, nwr, nrd);
    chk("mis_lw_flag",   32'(mis), 32'd1);
    chk("mis_lw_data",   d,        32'd0);
    chk("mis_lw_lat",    32'(lat), 32'd1);
    chk("mis_lw_nrd",    32'(nrd), 32'd0);
    do_req(1'b1, 2'd1, 1'b0, 11'h011, 32'hFFFF_FFFF, d, mis, lat, nwr, nrd);
    chk("mis_sh_flag",   32'(mis), 32'd1);
    chk("mis_sh_nwr",    32'(nwr + nrd), 32'd0);
    chk("mis_mem",       mem[4],   32'h80011234);

    // Reset during the read phase of a byte store.
    do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'h11223344, d, mis, lat, nwr, nrd);
    @(negedge clk);
    reqValid  = 1'b1;
    reqWrite  = 1'b1;
    reqSize   = 2'd0;
    reqSigned = 1'b0;
    reqAddr   = 11'h011;
    reqWData  = 32'h0000_00AA;
    @(negedge clk);
    reqValid = 1'b0;
    chk("rst_mid_in_rmw", MemRead, 32'd1);
    rst_n   = 1'b0;
    cnt_wr  = 0;
    cnt_rsp = 0;
    repeat (2) begin
      @(negedge clk);
      cnt_wr  += int'(MemWrite);
      cnt_rsp += int'(rspValid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", reqReady, 32'd1);
    repeat (4) begin
      cnt_wr  += int'(MemWrite);
      cnt_rsp += int'(rspValid);
      @(negedge clk);
    end
    chk("rst_mid_nwr",   32'(cnt_wr),  32'd0);
    chk("rst_mid_nrsp",  32'(cnt_rsp), 32'd0);
    chk("rst_mid_mem",   mem[4],       32'h11223344);

    // Back-to-back with reqValid held high.
    @(negedge clk);
    reqValid  = 1'b1;
    reqWrite  = 1'b1;
    reqSize   = 2'd2;
    reqSigned = 1'b0;
    reqAddr   = 11'h020;
    reqWData  = 32'h12345678;
    @(negedge clk);
    reqWrite = 1'b0;
    reqWData = 32'h0;
    chk("b2b_ready_write", reqReady, 32'd0);
    @(negedge clk);
    chk("b2b_ready_resp",  reqReady, 32'd0);
    chk("b2b_rsp1",        rspValid, 32'd1);
    @(negedge clk);
    chk("b2b_ready_idle",  reqReady, 32'd1);
    @(negedge clk);
    reqValid = 1'b0;
    chk("b2b_load_rd",     MemRead,  32'd1);
    @(negedge clk);
    chk("b2b_rsp2",        rspValid, 32'd1);
    chk("b2b_rsp2_data",   rspData,  32'h12345678);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reqValid  = ($urandom_range(0, 3) != 0);
      reqWrite  = 1'($urandom_range(0, 1));
      r         = int'($urandom_range(0, 9));
      reqSize   = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      reqSigned = 1'($urandom_range(0, 1));
      reqAddr   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 63)) : AW'($urandom);
      reqWData  = $urandom;
    end
    @(negedge clk);
    reqValid = 1'b0;
    repeat (6) @(negedge clk);

    bad_words = 0;
    for (int i = 0; i < int'(NWORDS); i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (bad_words == 0)
          $display("first differing word %0d: memory %h reference %h", i, mem[i], ref_mem[i]);
        bad_words++;
      end
    end
    chk("final_memory_words_differing", 32'(bad_words), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
